// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial memory controller.
// State encoding, access-size codes and the IO-window address test.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite
    } state_e;

    localparam logic [1:0] SizeByte = 2'd0;
    localparam logic [1:0] SizeHalf = 2'd1;
    localparam logic [1:0] SizeWord = 2'd2;

    localparam logic [1:0] IO_HI = 2'b11;

    function automatic logic is_io(input logic [1:0] addr_hi);
        return addr_hi == IO_HI;
    endfunction

    // Size code 3 falls through to a full word.
    function automatic logic [2:0] size_len(input logic [1:0] size);
        logic [2:0] len;
        case (size)
            SizeByte: len = 3'd1;
            SizeHalf: len = 3'd2;
            default:  len = 3'd4;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates IF and LS requests and sequences
// 1/2/4-byte accesses over the 8-bit memory bus.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata
);

    state_e      state_q, state_d;
    logic [31:0] base_q;
    logic [31:0] wdata_q;
    logic [31:0] res_q, res_d;
    logic [31:0] if_data_q, ls_rdata_q;
    logic [2:0]  cnt_q, len_q;
    logic        owner_ls_q;
    logic        stale_q;
    logic        if_done_q, ls_done_q;

    logic        accept;
    logic        io_stall;
    logic        stale_reissue;
    logic        capture;
    logic        read_last;
    logic        write_last;
    logic        flush_abort;
    logic [31:0] off;
    logic [4:0]  cap_idx;

    assign off           = {29'd0, cnt_q};
    assign cap_idx       = {cnt_q[1:0] - 2'd1, 3'b000};
    assign accept        = rdy_in & ~if_done_q & ~ls_done_q & (ls_req | (if_req & ~flush));
    assign io_stall      = is_io(base_q[17:16]) & io_buffer_full;
    // After a pause the byte whose capture was skipped must be re-addressed first.
    assign stale_reissue = stale_q & (cnt_q != 3'd0);
    assign capture       = (state_q == StRead) & ~stale_reissue & (cnt_q != 3'd0);
    assign read_last     = (state_q == StRead) & ~stale_reissue & (cnt_q == len_q);
    assign write_last    = (state_q == StWrite) & ~io_stall & (cnt_q == len_q - 3'd1);
    assign flush_abort   = (state_q == StRead) & ~owner_ls_q & flush;

    always_comb begin
        res_d = res_q;
        if (capture) begin
            res_d[cap_idx +: 8] = mem_din;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rdy_in) begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_d = (ls_req & ls_we) ? StWrite : StRead;
                    end
                end
                StRead: begin
                    if (flush_abort || read_last) begin
                        state_d = StIdle;
                    end
                end
                StWrite: begin
                    if (write_last) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        mem_a    = 32'd0;
        mem_dout = 8'd0;
        mem_wr   = 1'b0;
        unique case (state_q)
            StRead: begin
                if (stale_reissue) begin
                    mem_a = base_q + off - 32'd1;
                end else if (cnt_q < len_q) begin
                    mem_a = base_q + off;
                end
            end
            StWrite: begin
                mem_a    = base_q + off;
                mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                mem_wr   = rdy_in & ~io_stall;
            end
            default: ;
        endcase
    end

    assign if_done  = if_done_q & ~flush;
    assign ls_done  = ls_done_q;
    assign if_data  = if_data_q;
    assign ls_rdata = ls_rdata_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            base_q     <= 32'd0;
            wdata_q    <= 32'd0;
            res_q      <= 32'd0;
            if_data_q  <= 32'd0;
            ls_rdata_q <= 32'd0;
            cnt_q      <= 3'd0;
            len_q      <= 3'd0;
            owner_ls_q <= 1'b0;
            stale_q    <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
        end else begin
            stale_q <= ~rdy_in & (state_q == StRead);
            if (rdy_in) begin
                if_done_q <= read_last & ~owner_ls_q & ~flush;
                ls_done_q <= (read_last & owner_ls_q) | write_last;
                unique case (state_q)
                    StIdle: begin
                        if (accept) begin
                            base_q     <= ls_req ? ls_addr : if_addr;
                            len_q      <= ls_req ? size_len(ls_size) : 3'd4;
                            wdata_q    <= ls_wdata;
                            owner_ls_q <= ls_req;
                            cnt_q      <= 3'd0;
                            res_q      <= 32'd0;
                        end
                    end
                    StRead: begin
                        if (!stale_reissue) begin
                            res_q <= res_d;
                            cnt_q <= cnt_q + 3'd1;
                        end
                        if (read_last) begin
                            if (owner_ls_q) begin
                                ls_rdata_q <= res_d;
                            end else if (!flush) begin
                                if_data_q <= res_d;
                            end
                        end
                    end
                    StWrite: begin
                        if (!io_stall) begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a vector table of load/store accesses plus
// directed sequences for arbitration, IO stall, flush, pause and reset.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full, flush;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        ls_req, ls_we, ls_done;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [1:0]  ls_size;

    logic        preload;
    logic [7:0]  ram [0:1023];

    int total = 0;
    int bad   = 0;

    mem_ctrl dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full),
        .flush          (flush),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .ls_req         (ls_req),
        .ls_we          (ls_we),
        .ls_addr        (ls_addr),
        .ls_size        (ls_size),
        .ls_wdata       (ls_wdata),
        .ls_done        (ls_done),
        .ls_rdata       (ls_rdata)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous RAM; data read while paused is lost (HCI owns the bus).
    always @(posedge clk_in) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
            ram[10'h100] <= 8'h13; ram[10'h101] <= 8'h05;
            ram[10'h200] <= 8'hFF; ram[10'h201] <= 8'h5A;
            ram[10'h080] <= 8'h11; ram[10'h081] <= 8'h22;
            ram[10'h082] <= 8'h33; ram[10'h083] <= 8'h44;
            ram[10'h084] <= 8'h55; ram[10'h085] <= 8'h66;
            ram[10'h086] <= 8'h77; ram[10'h087] <= 8'h88;
            ram[10'h040] <= 8'h93; ram[10'h042] <= 8'h10;
        end else if (mem_wr) begin
            ram[mem_a[9:0]] <= mem_dout;
        end
        mem_din <= rdy_in ? ram[mem_a[9:0]] : 8'hEE;
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
        int          wr;
    } vec_t;

    vec_t vecs [12];

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ls_op(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output int lat, output int wrs);
        step();
        ls_req = 1'b1; ls_we = we; ls_size = size; ls_addr = addr; ls_wdata = wdata;
        lat = -1; wrs = 0; rdata = 32'hx;
        for (int k = 1; k <= 40; k++) begin
            step();
            #1;
            if (mem_wr) wrs++;
            if (ls_done) begin
                lat = k; rdata = ls_rdata;
                break;
            end
        end
        step();
        ls_req = 1'b0; ls_we = 1'b0;
    endtask

    logic [31:0] addr_log [4];

    task automatic if_op(input logic [31:0] addr, output logic [31:0] data, output int lat);
        step();
        if_req = 1'b1; if_addr = addr;
        lat = -1; data = 32'hx;
        for (int k = 1; k <= 40; k++) begin
            step();
            #1;
            if (k <= 4) addr_log[k-1] = mem_a;
            if (if_done) begin
                lat = k; data = if_data;
                break;
            end
        end
        step();
        if_req = 1'b0;
    endtask

    logic [31:0] rd, fd, a3, a4, a5;
    int          lat, wrs, ls_k, if_k;
    logic        seen;

    initial begin
        vecs[0]  = '{1'b0, 2'd0, 32'h200, 32'h0,        32'h000000FF, 3, 0};
        vecs[1]  = '{1'b0, 2'd1, 32'h081, 32'h0,        32'h00003322, 4, 0};
        vecs[2]  = '{1'b0, 2'd2, 32'h080, 32'h0,        32'h44332211, 6, 0};
        vecs[3]  = '{1'b0, 2'd2, 32'h083, 32'h0,        32'h77665544, 6, 0};
        vecs[4]  = '{1'b0, 2'd3, 32'h084, 32'h0,        32'h88776655, 6, 0};
        vecs[5]  = '{1'b1, 2'd1, 32'h1FF, 32'hA1B2C3D4, 32'h0,        3, 2};
        vecs[6]  = '{1'b0, 2'd1, 32'h1FF, 32'h0,        32'h0000C3D4, 4, 0};
        vecs[7]  = '{1'b0, 2'd0, 32'h201, 32'h0,        32'h0000005A, 3, 0};
        vecs[8]  = '{1'b1, 2'd2, 32'h090, 32'hDEADBEEF, 32'h0,        5, 4};
        vecs[9]  = '{1'b0, 2'd2, 32'h090, 32'h0,        32'hDEADBEEF, 6, 0};
        vecs[10] = '{1'b1, 2'd0, 32'h0A0, 32'h12345678, 32'h0,        2, 1};
        vecs[11] = '{1'b0, 2'd2, 32'h0A0, 32'h0,        32'h00000078, 6, 0};

        rst_in = 1'b1; preload = 1'b1; rdy_in = 1'b1;
        io_buffer_full = 1'b0; flush = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'h0; ls_size = 2'd0; ls_wdata = 32'h0;
        repeat (3) step();
        rst_in = 1'b0; preload = 1'b0;
        #1;
        check("reset mem_a", mem_a, 32'h0);
        check("reset mem_wr", {31'd0, mem_wr}, 32'h0);
        check("reset mem_dout", {24'd0, mem_dout}, 32'h0);
        check("reset done", {30'd0, if_done, ls_done}, 32'h0);
        check("reset data", if_data | ls_rdata, 32'h0);

        // Word fetch
        if_op(32'h100, fd, lat);
        check("fetch data", fd, 32'h00000513);
        check("fetch latency", lat, 6);
        for (int i = 0; i < 4; i++) check("fetch mem_a", addr_log[i], 32'h100 + i);

        // Arbitration: LS wins, IF follows the cycle after ls_done
        step();
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h200;
        ls_k = -1; if_k = -1; a5 = 32'hx; rd = 32'hx; fd = 32'hx;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (ls_k >= 0) ls_req = 1'b0;
            #1;
            if (k == 5) a5 = mem_a;
            if (ls_done && ls_k < 0) begin ls_k = k; rd = ls_rdata; end
            if (if_done) begin if_k = k; fd = if_data; break; end
        end
        step();
        if_req = 1'b0; ls_req = 1'b0;
        check("arb ls latency", ls_k, 3);
        check("arb ls data", rd, 32'h000000FF);
        check("arb if start addr", a5, 32'h100);
        check("arb if latency", if_k, 10);
        check("arb if data", fd, 32'h00000513);

        // Table of loads and stores
        for (int v = 0; v < 12; v++) begin
            ls_op(vecs[v].we, vecs[v].size, vecs[v].addr, vecs[v].wdata, rd, lat, wrs);
            check($sformatf("vec%0d latency", v), lat, vecs[v].lat);
            check($sformatf("vec%0d wr cycles", v), wrs, vecs[v].wr);
            if (!vecs[v].we) check($sformatf("vec%0d rdata", v), rd, vecs[v].exp);
        end
        check("ram 0x200 after half store", {24'd0, ram[10'h200]}, 32'hC3);

        // IO stall: three blocked cycles, then one write
        step();
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h30000; ls_wdata = 32'h41;
        io_buffer_full = 1'b1;
        lat = -1; wrs = 0; a4 = 32'h0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 4) io_buffer_full = 1'b0;
            #1;
            if (k <= 3 && mem_wr) wrs++;
            if (k == 4) a4 = {mem_a[31:1], mem_wr} ^ {24'd0, mem_dout};
            if (ls_done) begin lat = k; break; end
        end
        step();
        ls_req = 1'b0; ls_we = 1'b0; io_buffer_full = 1'b0;
        check("io stalled writes", wrs, 0);
        check("io write beat", a4, 32'h30001 ^ 32'h41);
        check("io latency", lat, 5);

        // Flush during byte 2 of a fetch
        step();
        if_req = 1'b1; if_addr = 32'h100; seen = 1'b0; a3 = 32'hx; a4 = 32'hx;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 3) begin flush = 1'b1; if_req = 1'b0; end
            if (k == 4) flush = 1'b0;
            #1;
            if (k == 3) a3 = mem_a;
            if (k == 4) a4 = mem_a;
            if (if_done) seen = 1'b1;
        end
        check("flush byte2 addr", a3, 32'h102);
        check("flush idle addr", a4, 32'h0);
        check("flush no if_done", {31'd0, seen}, 32'h0);
        if_op(32'h40, fd, lat);
        check("post-flush data", fd, 32'h00100093);
        check("post-flush latency", lat, 6);

        // Pause mid word-load
        step();
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h080;
        lat = -1; wrs = 0; rd = 32'hx;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 3) rdy_in = 1'b0;
            if (k == 7) rdy_in = 1'b1;
            #1;
            if (mem_wr) wrs++;
            if (ls_done && rdy_in) begin lat = k; rd = ls_rdata; break; end
        end
        step();
        ls_req = 1'b0; rdy_in = 1'b1;
        check("pause load data", rd, 32'h44332211);
        check("pause load wr", wrs, 0);
        check("pause load done", {31'd0, lat > 0}, 32'h1);

        // Pause mid word-store
        step();
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h0B0; ls_wdata = 32'h01020304;
        lat = -1; wrs = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 2) rdy_in = 1'b0;
            if (k == 4) rdy_in = 1'b1;
            #1;
            if (mem_wr) wrs++;
            if (ls_done && rdy_in) begin lat = k; break; end
        end
        step();
        ls_req = 1'b0; ls_we = 1'b0; rdy_in = 1'b1;
        check("pause store wr", wrs, 4);
        check("pause store latency", lat, 7);
        ls_op(1'b0, 2'd2, 32'h0B0, 32'h0, rd, lat, wrs);
        check("pause store readback", rd, 32'h01020304);

        // Reset in the middle of a store
        step();
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h0C0; ls_wdata = 32'hCAFEF00D;
        step();
        step();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        #1;
        check("rst mem_a", mem_a, 32'h0);
        check("rst mem_wr/dout", {23'd0, mem_wr, mem_dout}, 32'h0);
        check("rst done", {30'd0, if_done, ls_done}, 32'h0);
        check("rst data", if_data | ls_rdata, 32'h0);
        step();
        check("rst partial byte0", {24'd0, ram[10'h0C0]}, 32'h0D);
        check("rst untouched byte2", {24'd0, ram[10'h0C2]}, 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
